// File: rtl/branch_resolve_queue_pkg.sv
// Shared definitions for the branch resolve queue: default widths, entry layout, FSM states.
// An entry is packed as {pc, index, taken}, with taken in bit 0.
package branch_resolve_queue_pkg;

  localparam int IDX_W_DEF = 4;
  localparam int PC_W_DEF  = 8;

  typedef enum logic {
    ST_NORMAL  = 1'b0,
    ST_RECOVER = 1'b1
  } brq_state_e;

  function automatic int brq_entry_w(input int pc_w, input int idx_w);
    return pc_w + idx_w + 1;
  endfunction

endpackage

// File: rtl/brq_fifo.sv
// Circular in-order storage for in-flight branch entries with pointer, count and flush.
// A flush always coincides with retiring the head, so it discards everything behind it.
module brq_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 13,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  assign rdata = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= rd_ptr + 1'b1;
      wr_ptr <= rd_ptr + 1'b1;
      count  <= '0;
    end else begin
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order tracker between the global predictor and branch resolution: compares predictions
// with outcomes, emits registered BHT update / mispredict strobes and flushes the wrong path.
module branch_resolve_queue
  import branch_resolve_queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int IDX_W = IDX_W_DEF,
  parameter  int PC_W  = PC_W_DEF,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pred_valid,
  output logic             pred_ready,
  input  logic [PC_W-1:0]  pred_pc,
  input  logic [IDX_W-1:0] pred_index,
  input  logic             pred_taken,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic             res_taken,
  output logic             upd_valid,
  output logic [IDX_W-1:0] upd_index,
  output logic             upd_taken,
  output logic             mispredict,
  output logic [IDX_W-1:0] recover_ghr,
  output logic [PC_W-1:0]  upd_pc,
  output logic [CNT_W-1:0] count
);

  localparam int ENTRY_W = brq_entry_w(PC_W, IDX_W);

  brq_state_e         state;
  brq_state_e         state_next;
  logic               full;
  logic               empty;
  logic               pop;
  logic               push;
  logic               mis_now;
  logic [ENTRY_W-1:0] head;
  logic [ENTRY_W-1:0] wdata;
  logic [PC_W-1:0]    head_pc;
  logic [IDX_W-1:0]   head_index;
  logic               head_taken;

  assign {head_pc, head_index, head_taken} = head;
  assign wdata = {pred_pc, pred_index, pred_taken};

  // Derived from state/empty directly so pred_ready never loops back through res_ready.
  assign pop     = res_valid && !empty && (state == ST_NORMAL);
  assign mis_now = pop && (head_taken != res_taken);
  assign push    = pred_valid && pred_ready && !mis_now;

  brq_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (mis_now),
    .wdata (wdata),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= ST_NORMAL;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_NORMAL:  if (mis_now) state_next = ST_RECOVER;
      ST_RECOVER: state_next = ST_NORMAL;
    endcase
  end

  // A correct pop frees a slot this cycle, so a full queue can still accept a push.
  always_comb begin
    res_ready  = 1'b0;
    pred_ready = 1'b0;
    if (state == ST_NORMAL) begin
      res_ready  = !empty;
      pred_ready = !full || (pop && !mis_now);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      upd_valid   <= 1'b0;
      mispredict  <= 1'b0;
      upd_taken   <= 1'b0;
      upd_index   <= '0;
      recover_ghr <= '0;
      upd_pc      <= '0;
    end else begin
      upd_valid  <= pop;
      mispredict <= mis_now;
      if (pop) begin
        upd_index   <= head_index;
        upd_taken   <= res_taken;
        upd_pc      <= head_pc;
        recover_ghr <= {head_index[IDX_W-2:0], res_taken};
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Bench for branch_resolve_queue: directed scenarios plus random traffic on DEPTH=4 and 8,
// checked against a queue-based model of the resolve/flush rules.
module tb_branch_resolve_queue;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pred_valid_s [2];
  logic [7:0] pred_pc_s    [2];
  logic [3:0] pred_index_s [2];
  logic       pred_taken_s [2];
  logic       res_valid_s  [2];
  logic       res_taken_s  [2];
  logic       pred_ready_s [2];
  logic       res_ready_s  [2];
  logic       upd_valid_s  [2];
  logic [3:0] upd_index_s  [2];
  logic       upd_taken_s  [2];
  logic       mispredict_s [2];
  logic [3:0] recover_ghr_s[2];
  logic [7:0] upd_pc_s     [2];
  logic [2:0] count0;
  logic [3:0] count1;

  int errors = 0;
  int checks = 0;
  int sel = 0;
  int depth = 4;
  logic [12:0] mq[$];
  bit recover = 1'b0;

  always #5 clk = ~clk;

  branch_resolve_queue #(.DEPTH(4)) dut4 (
    .clk(clk), .reset(reset),
    .pred_valid(pred_valid_s[0]), .pred_ready(pred_ready_s[0]), .pred_pc(pred_pc_s[0]),
    .pred_index(pred_index_s[0]), .pred_taken(pred_taken_s[0]),
    .res_valid(res_valid_s[0]), .res_ready(res_ready_s[0]), .res_taken(res_taken_s[0]),
    .upd_valid(upd_valid_s[0]), .upd_index(upd_index_s[0]), .upd_taken(upd_taken_s[0]),
    .mispredict(mispredict_s[0]), .recover_ghr(recover_ghr_s[0]), .upd_pc(upd_pc_s[0]),
    .count(count0)
  );

  branch_resolve_queue #(.DEPTH(8)) dut8 (
    .clk(clk), .reset(reset),
    .pred_valid(pred_valid_s[1]), .pred_ready(pred_ready_s[1]), .pred_pc(pred_pc_s[1]),
    .pred_index(pred_index_s[1]), .pred_taken(pred_taken_s[1]),
    .res_valid(res_valid_s[1]), .res_ready(res_ready_s[1]), .res_taken(res_taken_s[1]),
    .upd_valid(upd_valid_s[1]), .upd_index(upd_index_s[1]), .upd_taken(upd_taken_s[1]),
    .mispredict(mispredict_s[1]), .recover_ghr(recover_ghr_s[1]), .upd_pc(upd_pc_s[1]),
    .count(count1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] cnt();
    return (sel != 0) ? 32'(count1) : 32'(count0);
  endfunction

  task automatic clear_inputs();
    for (int k = 0; k < 2; k++) begin
      pred_valid_s[k] = 1'b0; pred_pc_s[k] = '0; pred_index_s[k] = '0;
      pred_taken_s[k] = 1'b0; res_valid_s[k] = 1'b0; res_taken_s[k] = 1'b0;
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_upd_valid", upd_valid_s[k], 0);
      chk("rst_mispredict", mispredict_s[k], 0);
      chk("rst_upd_taken", upd_taken_s[k], 0);
      chk("rst_upd_index", upd_index_s[k], 0);
      chk("rst_recover_ghr", recover_ghr_s[k], 0);
      chk("rst_upd_pc", upd_pc_s[k], 0);
      chk("rst_res_ready", res_ready_s[k], 0);
      chk("rst_pred_ready", pred_ready_s[k], 1);
    end
    chk("rst_count4", 32'(count0), 0);
    chk("rst_count8", 32'(count1), 0);
    reset = 1'b1;
    mq.delete();
    recover = 1'b0;
  endtask

  // Called at a negedge; returns at the following negedge with that cycle's results visible.
  task automatic cycle(input bit pv, input logic [7:0] pc, input logic [3:0] idx, input bit pt,
                       input bit rv, input bit rt);
    bit pop, mis, push, rrdy, prdy;
    logic [12:0] head;
    pred_valid_s[sel] = pv; pred_pc_s[sel] = pc; pred_index_s[sel] = idx;
    pred_taken_s[sel] = pt; res_valid_s[sel] = rv; res_taken_s[sel] = rt;
    #1;
    rrdy = !recover && (mq.size() > 0);
    pop  = rv && rrdy;
    head = pop ? mq[0] : 13'h0;
    mis  = pop && (head[0] != rt);
    prdy = !recover && ((mq.size() < depth) || (pop && !mis));
    push = pv && prdy && !mis;
    chk("res_ready", res_ready_s[sel], rrdy);
    chk("pred_ready", pred_ready_s[sel], prdy);
    @(posedge clk);
    recover = mis;
    if (pop) void'(mq.pop_front());
    if (mis) mq.delete();
    if (push) mq.push_back({pc, idx, pt});
    #1;
    chk("upd_valid", upd_valid_s[sel], pop);
    chk("mispredict", mispredict_s[sel], mis);
    chk("count", cnt(), mq.size());
    if (pop) begin
      chk("upd_index", upd_index_s[sel], head[4:1]);
      chk("upd_taken", upd_taken_s[sel], rt);
      chk("upd_pc", upd_pc_s[sel], head[12:5]);
      if (mis) chk("recover_ghr", recover_ghr_s[sel], {head[3:1], rt});
    end
    @(negedge clk);
  endtask

  initial begin
    bit rt;
    clear_inputs();
    @(negedge clk);
    sel = 0; depth = 4;
    do_reset();

    // 1: single correct resolve
    cycle(1, 8'h10, 4'h3, 1, 0, 0);
    cycle(0, 8'h00, 4'h0, 0, 1, 1);
    chk("t1_upd_valid", upd_valid_s[0], 1);
    chk("t1_upd_index", upd_index_s[0], 4'h3);
    chk("t1_upd_taken", upd_taken_s[0], 1);
    chk("t1_mispredict", mispredict_s[0], 0);
    chk("t1_count", 32'(count0), 0);

    // 2: fill, overflow push dropped, in-order drain
    for (int i = 0; i < 4; i++) cycle(1, 8'(8'h20 + i), 4'(i), 1'(i), 0, 0);
    chk("t2_count_full", 32'(count0), 4);
    chk("t2_pred_ready_full", pred_ready_s[0], 0);
    cycle(1, 8'h99, 4'h9, 0, 0, 0);
    chk("t2_count_after_drop", 32'(count0), 4);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 8'h00, 4'h0, 0, 1, 1'(i));
      chk("t2_order", upd_index_s[0], 4'(i));
    end

    // 3: mispredict, flush, one RECOVER cycle
    cycle(1, 8'h30, 4'hA, 0, 0, 0);
    cycle(1, 8'h31, 4'h5, 1, 0, 0);
    cycle(1, 8'h32, 4'h6, 1, 0, 0);
    cycle(0, 8'h00, 4'h0, 0, 1, 1);
    chk("t3_mispredict", mispredict_s[0], 1);
    chk("t3_recover_ghr", recover_ghr_s[0], 4'h5);
    chk("t3_count", 32'(count0), 0);
    chk("t3_recover_pred_ready", pred_ready_s[0], 0);
    chk("t3_recover_res_ready", res_ready_s[0], 0);
    cycle(1, 8'h33, 4'h7, 0, 1, 0);
    chk("t3_normal_pred_ready", pred_ready_s[0], 1);

    // 4: full queue with simultaneous push and pop
    for (int i = 0; i < 4; i++) cycle(1, 8'(8'h40 + i), 4'(i + 1), 1'(i), 0, 0);
    chk("t4_count_full", 32'(count0), 4);
    rt = mq[0][0];
    cycle(1, 8'h4E, 4'hE, 0, 1, rt);
    chk("t4_count_hold", 32'(count0), 4);
    for (int i = 0; i < 4; i++) begin
      rt = mq[0][0];
      cycle(0, 8'h00, 4'h0, 0, 1, rt);
    end
    chk("t4_new_entry_last", upd_index_s[0], 4'hE);
    for (int i = 0; i < 3; i++) cycle(1, 8'(8'h50 + i), 4'(i + 8), 1, 0, 0);
    rt = ~mq[0][0];
    cycle(1, 8'h5F, 4'hF, 1, 1, rt);
    chk("t4_flush_count", 32'(count0), 0);
    chk("t4_flush_mispredict", mispredict_s[0], 1);
    cycle(0, 8'h00, 4'h0, 0, 0, 0);

    // 5: reset mid-stream with a strobe pending
    for (int i = 0; i < 3; i++) cycle(1, 8'(8'h60 + i), 4'(i + 2), 1, 0, 0);
    pred_valid_s[0] = 1'b0; res_valid_s[0] = 1'b1; res_taken_s[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_strobe_pending", upd_valid_s[0], 1);
    reset = 1'b0;
    #1;
    chk("t5_rst_upd_valid", upd_valid_s[0], 0);
    chk("t5_rst_count", 32'(count0), 0);
    clear_inputs();
    mq.delete();
    recover = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    cycle(0, 8'h00, 4'h0, 0, 1, 1);
    chk("t5_empty_no_strobe", upd_valid_s[0], 0);

    // 6: random traffic on both depths
    for (int s = 0; s < 2; s++) begin
      sel = s;
      depth = (s != 0) ? 8 : 4;
      do_reset();
      repeat (200) begin
        bit pv, rv;
        pv = ($urandom_range(0, 9) < 6);
        rv = ($urandom_range(0, 9) < 5);
        if (mq.size() > 0) rt = mq[0][0] ^ ($urandom_range(0, 5) == 0);
        else rt = 1'($urandom_range(0, 1));
        cycle(pv, 8'($urandom), 4'($urandom), 1'($urandom), rv, rt);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
